// File: rtl/alu_pkg.sv
// alu_pkg: shared op encoding, flag indices and default width for the RISC ALU.
package alu_pkg;
  localparam int ALU_WIDTH = 16;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_e;
endpackage

// File: rtl/risc_alu_addsub.sv
// risc_alu_addsub: WIDTH-bit adder; sub inverts b and injects carry-in for two's-complement subtract.
module risc_alu_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);
  logic [WIDTH-1:0] b_eff;
  assign b_eff = sub_i ? ~b_i : b_i;
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};
endmodule

// File: rtl/risc_alu.sv
// risc_alu: combinational ADD/SUB/AND/NOT datapath with {C,N,Z} flags and a loadable status register.
module risc_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [1:0]       ALUop,
  input  logic             load_status,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       Z,
  output logic [2:0]       status
);
  alu_op_e          op;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [2:0]       status_q, status_d;
  assign op = alu_op_e'(ALUop);
  risc_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a_i    (Ain),
    .b_i    (Bin),
    .sub_i  (op == ALU_SUB),
    .sum_o  (sum),
    .carry_o(carry)
  );
  always_comb begin
    out = op == ALU_AND ? (Ain & Bin) : op == ALU_NOT ? ~Bin : sum;
    Z = '0;
    Z[FLAG_C] = (op == ALU_ADD || op == ALU_SUB) ? carry : 1'b0;
    Z[FLAG_N] = out[WIDTH-1];
    Z[FLAG_Z] = out == '0;
    status_d = load_status ? Z : status_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) status_q <= '0;
    else status_q <= status_d;
  assign status = status_q;
endmodule

// File: tb/tb_risc_alu.sv
// tb_risc_alu: directed plus randomized checks of risc_alu against an arithmetic reference model.
module tb_risc_alu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] Ain = '0, Bin = '0;
  logic [1:0]  ALUop = '0;
  logic        load_status = 1'b0;
  logic [15:0] out;
  logic [2:0]  Z, status;
  int          total = 0, bad = 0;
  logic [2:0]  exp_st;
  logic [18:0] m;

  risc_alu dut (
    .clk(clk), .rst_n(rst_n), .Ain(Ain), .Bin(Bin), .ALUop(ALUop),
    .load_status(load_status), .out(out), .Z(Z), .status(status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // returns {C, N, Z, out}
  function automatic logic [18:0] ref_alu(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    int unsigned r;
    logic        c;
    logic [15:0] o;
    case (op)
      2'd0: begin r = 32'(a) + 32'(b); c = r > 32'd65535; end
      2'd1: begin r = 32'(a) - 32'(b); c = a >= b; end
      2'd2: begin r = 32'(a & b); c = 1'b0; end
      default: begin r = 32'h0000FFFF ^ 32'(b); c = 1'b0; end
    endcase
    o = r[15:0];
    return {c, o[15], o == 16'd0, o};
  endfunction

  task automatic apply(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                       input logic [15:0] eo, input logic [2:0] ez);
    Ain = a; Bin = b; ALUop = op;
    #1;
    chk({tag, "_out"}, 32'(out), 32'(eo));
    chk({tag, "_flags"}, 32'(Z), 32'(ez));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk("reset_async", 32'(status), 32'd0);
    apply("add_wrap", 16'hFFFF, 16'h0001, 2'b00, 16'h0000, 3'b101);
    apply("add_signed", 16'h7FFF, 16'h0001, 2'b00, 16'h8000, 3'b010);
    apply("add_plain", 16'h0003, 16'h0004, 2'b00, 16'h0007, 3'b000);
    apply("sub_neg", 16'h0003, 16'h0004, 2'b01, 16'hFFFF, 3'b010);
    apply("sub_equal", 16'h1234, 16'h1234, 2'b01, 16'h0000, 3'b101);
    apply("and", 16'hF0F0, 16'h0FF0, 2'b10, 16'h00F0, 3'b000);
    apply("not_zero_in", 16'h5555, 16'h0000, 2'b11, 16'hFFFF, 3'b010);
    apply("not_ones_in", 16'hAAAA, 16'hFFFF, 2'b11, 16'h0000, 3'b001);
    @(negedge clk);
    chk("reset_held", 32'(status), 32'd0);
    rst_n = 1'b1;
    apply("st_setup", 16'hFFFF, 16'h0001, 2'b00, 16'h0000, 3'b101);
    load_status = 1'b1;
    @(posedge clk); #1;
    chk("st_load", 32'(status), 32'b101);
    @(negedge clk);
    load_status = 1'b0;
    apply("st_hold_ops", 16'h0003, 16'h0004, 2'b00, 16'h0007, 3'b000);
    @(posedge clk); #1;
    chk("st_hold", 32'(status), 32'b101);
    #2 rst_n = 1'b0;
    #1 chk("st_reset_mid", 32'(status), 32'd0);
    load_status = 1'b1;
    apply("st_rst_ops", 16'h7FFF, 16'h0001, 2'b00, 16'h8000, 3'b010);
    @(posedge clk); #1;
    chk("st_reset_override", 32'(status), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load_status = 1'b0;
    exp_st = 3'b000;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      Ain = 16'($urandom);
      Bin = 16'($urandom);
      if (i % 8 == 0) Bin = Ain;
      if (i % 16 == 1) Bin = 16'hFFFF - Ain + 16'(i % 3);
      ALUop = 2'($urandom_range(0, 3));
      load_status = 1'($urandom);
      #1;
      m = ref_alu(Ain, Bin, ALUop);
      chk("rnd_out", 32'(out), 32'(m[15:0]));
      chk("rnd_flags", 32'(Z), 32'(m[18:16]));
      if (load_status) exp_st = m[18:16];
      @(posedge clk); #1;
      chk("rnd_status", 32'(status), 32'(exp_st));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/risc_alu.md
Name: risc_alu

Overview:
- 16-bit combinational datapath ALU for the RISC core's execute stage.
- Operands Ain/Bin come from the register-file / shifter path.
- Produces a result plus a 3-bit flag vector {C, N, Z}.
- A clocked status register captures the flags on request, for later branch/condition evaluation.

Parameters:
- WIDTH, 16, operand/result width in bits; all flag rules below are stated for WIDTH, MSB = WIDTH-1.

Ports:
- clk  input  1  system clock; status register updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; clears status register.
- Ain  input  WIDTH  operand A.
- Bin  input  WIDTH  operand B.
- ALUop  input  2  operation select.
- load_status  input  1  when 1 at a rising clk edge, status <= Z.
- out  output  WIDTH  combinational result.
- Z  output  3  combinational flags: Z[2]=C (carry out), Z[1]=N (negative), Z[0]=Z (zero).
- status  output  3  registered copy of Z; same bit layout.

Behaviour:
- out and Z are purely combinational: zero latency from Ain/Bin/ALUop; independent of clk and rst_n.
- ALUop decode:
  - 2'b00 ADD: out = Ain + Bin (mod 2^WIDTH); C = carry out of bit WIDTH-1.
  - 2'b01 SUB: out = Ain + ~Bin + 1 (mod 2^WIDTH); C = carry out of that addition (1 = no borrow, i.e. Ain >= Bin unsigned).
  - 2'b10 AND: out = Ain & Bin; C = 0.
  - 2'b11 NOT: out = ~Bin; Ain ignored; C = 0.
- N = out[WIDTH-1] for every op.
- Zero flag = 1 iff out == 0, for every op.
- No signed-overflow flag. 7FFF+1 yields N=1, C=0, Z=0 and nothing else is flagged.
- Status register, 3 bits:
  - rst_n low: status = 3'b000 immediately (asynchronous), held while low.
  - Reset release: no update until the next qualifying rising edge.
  - Rising clk with rst_n high and load_status=1: status <= current Z.
  - load_status=0: status holds.
  - Reset asserted mid-operation overrides any pending load.
- No X propagation requirement beyond standard synthesis semantics. A full 2-bit decode is required, with no latches.

Decomposition:
- Shared package alu_pkg holds:
  - typedef enum logic [1:0] alu_op_e {ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_NOT=2'b11}.
  - Flag index constants FLAG_C=2, FLAG_N=1, FLAG_Z=0.
  - WIDTH default.
- One sub-module, risc_alu_addsub:
  - WIDTH-bit adder with sub input (inverts B, carry-in = sub).
  - Returns sum and carry out. Used for ADD and SUB.
- Flag generation and status register stay in the top module.

Test Plan:
- ADD wrap: Ain=16'hFFFF, Bin=16'h0001, ALUop=00 -> out=16'h0000, Z=3'b101.
- ADD signed boundary: Ain=16'h7FFF, Bin=16'h0001, ALUop=00 -> out=16'h8000, Z=3'b010.
- ADD plain: Ain=16'h0003, Bin=16'h0004, ALUop=00 -> out=16'h0007, Z=3'b000. Then ALUop=01 with the same operands -> out=16'hFFFF, Z=3'b010.
- SUB equal: Ain=Bin=16'h1234, ALUop=01 -> out=16'h0000, Z=3'b101.
- AND/NOT:
  - Ain=16'hF0F0, Bin=16'h0FF0, ALUop=10 -> out=16'h00F0, Z=3'b000.
  - Bin=16'h0000, ALUop=11 -> out=16'hFFFF, Z=3'b010.
  - Bin=16'hFFFF, ALUop=11 -> out=16'h0000, Z=3'b001.
- Status register:
  - Drive rst_n=0 -> status=000 with no clock edge.
  - Release rst_n, set up the FFFF+1 case, load_status=1, one edge -> status=101.
  - load_status=0, change operands -> status stays 101.
  - Assert rst_n=0 mid-cycle -> status=000 immediately.
